dram_arbiter: RTL and testbench

// - Responder end of the video as/bus_ack fetch protocol plus CPU port; replaces per-requester testram reads.
// - Serves ICA (ch0), display file decoder (ch1) and CPU over one shared external DRAM/SDRAM port.
// - Fixed priority ch0 > ch1 > CPU, with a CPU starvation guard; one outstanding memory transaction.

---
 rtl/mcd212_pkg.sv | 25 ++
 rtl/dram_arb_select.sv | 30 +++
 rtl/dram_arbiter.sv | 148 ++++++++++++++
 tb/tb_dram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcd212_pkg.sv
// Shared types for the DRAM arbiter: FSM states, grant ids and the
// latched memory command bundle.
package mcd212_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    RESPOND
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_CH0,
    GNT_CH1,
    GNT_CPU
  } grant_t;

  typedef struct packed {
    logic [19:1] adr;
    logic        we;
    logic [1:0]  be;
    logic [15:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dram_arb_select.sv
// Combinational winner pick: ch0 > ch1 > CPU, with a forced CPU slot
// once the starvation guard trips.
module dram_arb_select
  import mcd212_pkg::*;
(
  input  logic   el_ch0,
  input  logic   el_ch1,
  input  logic   el_cpu,
  input  logic   force_cpu,
  output logic   valid,
  output grant_t gnt
);

  always_comb begin
    valid = 1'b1;
    gnt   = GNT_CH0;
    if (force_cpu) begin
      gnt = GNT_CPU;
    end else if (el_ch0) begin
      gnt = GNT_CH0;
    end else if (el_ch1) begin
      gnt = GNT_CH1;
    end else if (el_cpu) begin
      gnt = GNT_CPU;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shared DRAM port arbiter for ICA, display decoder and CPU with one
// outstanding transaction and a CPU starvation guard.
module dram_arbiter
  import mcd212_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] ch0_adr,
  input  logic        ch0_as,
  output logic [15:0] ch0_din,
  output logic        ch0_bus_ack,
  input  logic [21:0] ch1_adr,
  input  logic        ch1_as,
  output logic [15:0] ch1_din,
  output logic        ch1_bus_ack,
  input  logic [19:1] cpu_adr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic [18:0] mem_adr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int WW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);

  arb_state_t      state_q, state_d;
  grant_t          gnt_q, gnt_d;
  mem_cmd_t        cmd_q, cmd_d;
  logic [WW-1:0]   cpu_wait_q, cpu_wait_d;
  logic [15:0]     ch0_dat_q, ch0_dat_d;
  logic [15:0]     ch1_dat_q, ch1_dat_d;
  logic [15:0]     cpu_dat_q, cpu_dat_d;

  logic   el_ch0, el_ch1, el_cpu, force_cpu;
  logic   sel_valid;
  grant_t sel_gnt;
  logic   unused_adr_bits;

  assign unused_adr_bits = ^{ch0_adr[21:20], ch0_adr[0],
                             ch1_adr[21:20], ch1_adr[0]};

  assign el_ch0    = ch0_as & ~ch0_bus_ack;
  assign el_ch1    = ch1_as & ~ch1_bus_ack;
  assign el_cpu    = cpu_req & ~cpu_ack;
  assign force_cpu = el_cpu && (cpu_wait_q == WAIT_MAX);

  dram_arb_select u_sel (
    .el_ch0    (el_ch0),
    .el_ch1    (el_ch1),
    .el_cpu    (el_cpu),
    .force_cpu (force_cpu),
    .valid     (sel_valid),
    .gnt       (sel_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_CH0;
      cmd_q      <= '0;
      cpu_wait_q <= '0;
      ch0_dat_q  <= '0;
      ch1_dat_q  <= '0;
      cpu_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cmd_q      <= cmd_d;
      cpu_wait_q <= cpu_wait_d;
      ch0_dat_q  <= ch0_dat_d;
      ch1_dat_q  <= ch1_dat_d;
      cpu_dat_q  <= cpu_dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (sel_valid) state_d = ISSUE;
      ISSUE:     if (mem_ready) state_d = cmd_q.we ? RESPOND : WAIT_DATA;
      WAIT_DATA: if (mem_rvalid) state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Command capture, starvation counter and read data steering.
  always_comb begin
    gnt_d      = gnt_q;
    cmd_d      = cmd_q;
    cpu_wait_d = cpu_wait_q;
    ch0_dat_d  = ch0_dat_q;
    ch1_dat_d  = ch1_dat_q;
    cpu_dat_d  = cpu_dat_q;
    if (state_q == IDLE && sel_valid) begin
      gnt_d = sel_gnt;
      unique case (sel_gnt)
        GNT_CH0: cmd_d = '{adr: ch0_adr[19:1], we: 1'b0,
                           be: 2'b11, wdata: 16'h0};
        GNT_CH1: cmd_d = '{adr: ch1_adr[19:1], we: 1'b0,
                           be: 2'b11, wdata: 16'h0};
        default: cmd_d = '{adr: cpu_adr, we: cpu_we,
                           be: {cpu_uds, cpu_lds}, wdata: cpu_wdata};
      endcase
      if (sel_gnt == GNT_CPU) begin
        cpu_wait_d = '0;
      end else if (cpu_req && cpu_wait_q != WAIT_MAX) begin
        cpu_wait_d = cpu_wait_q + WW'(1);
      end
    end
    if (!cpu_req) cpu_wait_d = '0;
    if (state_q == WAIT_DATA && mem_rvalid) begin
      unique case (gnt_q)
        GNT_CH0: ch0_dat_d = mem_rdata;
        GNT_CH1: ch1_dat_d = mem_rdata;
        default: cpu_dat_d = mem_rdata;
      endcase
    end
  end

  always_comb begin
    mem_req     = (state_q == ISSUE);
    mem_adr     = cmd_q.adr;
    mem_we      = cmd_q.we;
    mem_be      = cmd_q.be;
    mem_wdata   = cmd_q.wdata;
    ch0_bus_ack = (state_q == RESPOND) && (gnt_q == GNT_CH0);
    ch1_bus_ack = (state_q == RESPOND) && (gnt_q == GNT_CH1);
    cpu_ack     = (state_q == RESPOND) && (gnt_q == GNT_CPU);
    ch0_din     = ch0_dat_q;
    ch1_din     = ch1_dat_q;
    cpu_rdata   = cpu_dat_q;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: vector table, ack scoreboard and a small
// memory responder, plus hand-written multi-cycle sequences.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] ch0_adr, ch1_adr;
  logic        ch0_as, ch1_as;
  logic [15:0] ch0_din, ch1_din;
  logic        ch0_bus_ack, ch1_bus_ack;
  logic [18:0] cpu_adr;
  logic        cpu_req, cpu_we, cpu_uds, cpu_lds;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic [18:0] mem_adr;
  logic        mem_req, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  int vectors = 0;
  int miscompares = 0;
  int rv_lat = 0;

  typedef struct {
    int          ch;
    logic        chk_data;
    logic [15:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int          ch;
    logic        we;
    logic [21:0] adr;
    logic        uds;
    logic        lds;
    logic [15:0] wdata;
    logic [18:0] exp_adr;
    logic [1:0]  exp_be;
    logic [15:0] exp_data;
  } vec_t;

  dram_arbiter #(.CPU_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .ch0_adr(ch0_adr), .ch0_as(ch0_as),
    .ch0_din(ch0_din), .ch0_bus_ack(ch0_bus_ack),
    .ch1_adr(ch1_adr), .ch1_as(ch1_as),
    .ch1_din(ch1_din), .ch1_bus_ack(ch1_bus_ack),
    .cpu_adr(cpu_adr), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_adr(mem_adr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [18:0] a);
    return (a == 19'h00080) ? 16'hBEEF : a[15:0] + 16'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int ch);
    return (ch == 0) ? ch0_bus_ack : (ch == 1) ? ch1_bus_ack : cpu_ack;
  endfunction

  function automatic logic any_out();
    return |{ch0_din, ch0_bus_ack, ch1_din, ch1_bus_ack, cpu_rdata,
             cpu_ack, mem_adr, mem_req, mem_we, mem_be, mem_wdata};
  endfunction

  // Memory responder: read data after 1+rv_lat cycles from acceptance.
  logic [18:0] rd_adr;
  always begin
    @(negedge clk);
    if (!reset && mem_req && mem_ready && !mem_we) begin
      rd_adr = mem_adr;
      repeat (1 + rv_lat) @(posedge clk);
      #1;
      mem_rvalid = 1'b1;
      mem_rdata  = model(rd_adr);
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
    end
  end

  // Scoreboard: every ack pops the next expected completion.
  always @(negedge clk) begin
    int n;
    sb_t e;
    logic [15:0] dout;
    if (!reset && (ch0_bus_ack || ch1_bus_ack || cpu_ack)) begin
      n = int'(ch0_bus_ack) + int'(ch1_bus_ack) + int'(cpu_ack);
      chk("ack_onehot", 32'(n), 32'd1);
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'({cpu_ack, ch1_bus_ack, ch0_bus_ack}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_chan", 32'({cpu_ack, ch1_bus_ack, ch0_bus_ack}),
            32'(1) << e.ch);
        dout = (e.ch == 0) ? ch0_din : (e.ch == 1) ? ch1_din : cpu_rdata;
        if (e.chk_data) chk("ack_data", 32'(dout), 32'(e.data));
      end
    end
  end

  task automatic drive(input int ch, input logic v, input vec_t r);
    case (ch)
      0: begin ch0_adr = r.adr; ch0_as = v; end
      1: begin ch1_adr = r.adr; ch1_as = v; end
      default: begin
        cpu_adr = r.adr[18:0]; cpu_we = r.we; cpu_uds = r.uds;
        cpu_lds = r.lds; cpu_wdata = r.wdata; cpu_req = v;
      end
    endcase
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    tick();
    drive(v.ch, 1'b1, v);
    sb_q.push_back('{v.ch, !v.we, v.exp_data});
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk("vec_mem_req", 32'(mem_req), 32'd1);
    chk("vec_mem_adr", 32'(mem_adr), 32'(v.exp_adr));
    chk("vec_mem_be", 32'(mem_be), 32'(v.exp_be));
    chk("vec_mem_we", 32'(mem_we), 32'(v.we));
    if (v.we) chk("vec_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
    n = 0;
    while (!ack_of(v.ch) && n < 20) begin @(negedge clk); n++; end
    chk("vec_ack_seen", 32'(ack_of(v.ch)), 32'd1);
    tick();
    drive(v.ch, 1'b0, v);
  endtask

  vec_t vecs[7];
  vec_t vz;

  initial begin
    int got, nv;
    logic rq[4], ak[4];
    logic d0, d1, dc;
    logic [21:0] b2b_adr[3];

    vecs[0] = '{0, 0, 22'h000100, 1, 1, 16'h0, 19'h00080, 2'b11, 16'hBEEF};
    vecs[1] = '{1, 0, 22'h000004, 1, 1, 16'h0, 19'h00002, 2'b11, 16'h0003};
    vecs[2] = '{0, 0, 22'h3FFFFF, 1, 1, 16'h0, 19'h7FFFF, 2'b11, 16'h0000};
    vecs[3] = '{2, 0, 22'h000005, 1, 1, 16'h0, 19'h00005, 2'b11, 16'h0006};
    vecs[4] = '{2, 1, 22'h012345, 1, 0, 16'hA55A, 19'h12345, 2'b10, 16'h0};
    vecs[5] = '{2, 1, 22'h000040, 0, 0, 16'h1234, 19'h00040, 2'b00, 16'h0};
    vecs[6] = '{2, 0, 22'h000001, 0, 1, 16'h0, 19'h00001, 2'b01, 16'h0002};
    vz = '{0, 0, 22'h0, 0, 0, 16'h0, 19'h0, 2'b00, 16'h0};

    reset = 1'b1;
    ch0_adr = '0; ch0_as = 0; ch1_adr = '0; ch1_as = 0;
    cpu_adr = '0; cpu_req = 0; cpu_we = 0; cpu_uds = 0; cpu_lds = 0;
    cpu_wdata = '0; mem_ready = 1; mem_rdata = '0; mem_rvalid = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs_zero", 32'(any_out()), 32'd0);
    tick();
    reset = 1'b0;

    // Latency: request cycle 0, mem_req cycle 1, ack cycle 3.
    tick();
    ch0_adr = 22'h000100; ch0_as = 1;
    sb_q.push_back('{0, 1'b1, 16'hBEEF});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rq[c] = mem_req; ak[c] = ch0_bus_ack;
    end
    tick();
    ch0_as = 0;
    chk("lat_req_c0", 32'(rq[0]), 32'd0);
    chk("lat_req_c1", 32'(rq[1]), 32'd1);
    chk("lat_ack_c2", 32'(ak[2]), 32'd0);
    chk("lat_ack_c3", 32'(ak[3]), 32'd1);
    repeat (2) tick();

    foreach (vecs[i]) run_vec(vecs[i]);
    repeat (2) tick();

    // All three request together: ch0, ch1, CPU in that order.
    ch0_adr = 22'h10; ch1_adr = 22'h20; cpu_adr = 19'h3;
    cpu_we = 0; cpu_uds = 1; cpu_lds = 1;
    ch0_as = 1; ch1_as = 1; cpu_req = 1;
    sb_q.push_back('{0, 1'b1, 16'h0009});
    sb_q.push_back('{1, 1'b1, 16'h0011});
    sb_q.push_back('{2, 1'b1, 16'h0004});
    got = 0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      @(negedge clk);
      d0 = ch0_bus_ack; d1 = ch1_bus_ack; dc = cpu_ack;
      if (d0 || d1 || dc) got++;
      tick();
      if (d0) ch0_as = 0;
      if (d1) ch1_as = 0;
      if (dc) cpu_req = 0;
    end
    chk("prio_acks", 32'(got), 32'd3);
    repeat (2) tick();

    // Starvation guard: CPU after exactly four video acks.
    ch0_adr = 22'h000100; ch1_adr = 22'h20; cpu_adr = 19'h7;
    ch0_as = 1; ch1_as = 1; cpu_req = 1;
    for (int k = 0; k < 4; k++) sb_q.push_back('{0, 1'b1, 16'hBEEF});
    sb_q.push_back('{2, 1'b1, 16'h0008});
    nv = 0; got = 0;
    for (int c = 0; c < 60 && got == 0; c++) begin
      @(negedge clk);
      if (ch0_bus_ack || ch1_bus_ack) nv++;
      if (cpu_ack) got = 1;
    end
    tick();
    ch0_as = 0; ch1_as = 0; cpu_req = 0;
    chk("starve_cpu_ack", 32'(got), 32'd1);
    chk("starve_video_acks", 32'(nv), 32'd4);
    repeat (2) tick();

    // CPU write with mem_ready low for three cycles.
    mem_ready = 0;
    cpu_adr = 19'h12345; cpu_we = 1; cpu_uds = 1; cpu_lds = 0;
    cpu_wdata = 16'hA55A; cpu_req = 1;
    sb_q.push_back('{2, 1'b0, 16'h0});
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) mem_ready = 1;
      if (c == 5) cpu_req = 0;
      @(negedge clk);
      if (c <= 4) begin
        chk("wr_req_held", 32'(mem_req), 32'd1);
        chk("wr_adr", 32'(mem_adr), 32'h12345);
        chk("wr_be", 32'(mem_be), 32'd2);
        chk("wr_data", 32'(mem_wdata), 32'hA55A);
        chk("wr_no_ack", 32'(cpu_ack), 32'd0);
      end else begin
        chk("wr_ack", 32'(cpu_ack), 32'd1);
      end
    end
    cpu_we = 0;
    repeat (2) tick();

    // Reset in WAIT_DATA, read data arrives after reset.
    rv_lat = 3;
    ch0_adr = 22'h000100; ch0_as = 1;
    repeat (3) tick();
    reset = 1; ch0_as = 0;
    @(negedge clk);
    chk("rst_mid_outs_zero", 32'(any_out()), 32'd0);
    tick();
    reset = 0;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ch0_bus_ack || ch1_bus_ack || cpu_ack) nv++;
    end
    chk("rst_no_ack", 32'(nv), 32'd0);
    rv_lat = 0;
    run_vec(vecs[0]);
    repeat (2) tick();

    // ch1 back-to-back with as held high.
    b2b_adr[0] = 22'h0; b2b_adr[1] = 22'h2; b2b_adr[2] = 22'h4;
    for (int k = 0; k < 3; k++) sb_q.push_back('{1, 1'b1, 16'(k + 1)});
    ch1_adr = b2b_adr[0]; ch1_as = 1;
    got = 0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      @(negedge clk);
      if (ch1_bus_ack) begin
        got++;
        tick();
        if (got < 3) ch1_adr = b2b_adr[got];
        else ch1_as = 0;
      end
    end
    chk("b2b_acks", 32'(got), 32'd3);
    repeat (3) tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    drive(0, 1'b0, vz);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
